alu_issue: RTL and testbench

- Execution-stage sequencer that sits in front of the combinational ALU and drives it.
- Accepts one decoded instruction over a valid/ready handshake and reads its operands from the register file (synchronous, 1-cycle read).
- Drives the ALU opcode, operands and carry-in, then captures Result/Flags. Writes the result back and maintains the architectural flags register.

---
 rtl/opcodes.sv | 42 ++++
 rtl/alu_issue.sv | 149 ++++++++++++++
 tb/tb_alu_issue.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/opcodes.sv
// Shared opcode set, flag bit positions, issue states and opcode class
// helpers used by the execution-stage sequencer and its environment.
package opcodes;

    typedef enum logic [4:0] {
        ADD, ADDI, ADDIB, ADC, ADCI,
        SUB, SUBI, SUBIB, SUC, SUCI,
        CMP, CMPI, NEG,
        AND, OR, XOR, NOT, NAND, NOR,
        LSL, LSR, ASR,
        LUI, LLI, LDW, SDW,
        BRANCH, INTERRUPT, PUSH, POP
    } Opcode_t;

    localparam int FLAGS_Z = 0;
    localparam int FLAGS_N = 1;
    localparam int FLAGS_C = 2;
    localparam int FLAGS_V = 3;

    typedef enum logic [1:0] {
        IDLE, READ, EXEC, WB
    } IssueState_t;

    function automatic logic sets_flags(Opcode_t op);
        return op inside {
            ADD, ADDI, ADDIB, ADC, ADCI,
            SUB, SUBI, SUBIB, SUC, SUCI,
            CMP, CMPI, NEG,
            AND, OR, XOR, NOT, NAND, NOR,
            LSL, LSR, ASR
        };
    endfunction

    function automatic logic writes_back(Opcode_t op);
        return !(op inside {CMP, CMPI, SDW, BRANCH, INTERRUPT});
    endfunction

    function automatic logic uses_carry(Opcode_t op);
        return op inside {ADC, ADCI, SUC, SUCI};
    endfunction

endpackage

// File: rtl/alu_issue.sv
// Execution-stage sequencer: accepts one decoded instruction, reads its
// operands, drives the combinational ALU, writes back and keeps flags.
// Ports: Instr* handshake/fields in, RegRd* RF read port, Alu* to/from
// the ALU, RegWe/RegWrAddr/RegWrData RF write port, FlagsOut, Busy.
module alu_issue
    import opcodes::*;
#(
    parameter int DATA_WIDTH     = 16,
    parameter int REG_ADDR_WIDTH = 3
) (
    input  logic                      Clock,
    input  logic                      nReset,
    input  logic                      InstrValid,
    output logic                      InstrReady,
    input  Opcode_t                   InstrOp,
    input  logic [REG_ADDR_WIDTH-1:0] InstrRd,
    input  logic [REG_ADDR_WIDTH-1:0] InstrRa,
    input  logic [REG_ADDR_WIDTH-1:0] InstrRb,
    input  logic [DATA_WIDTH-1:0]     InstrImm,
    input  logic                      InstrUseImm,
    output logic [REG_ADDR_WIDTH-1:0] RegRdAddrA,
    output logic [REG_ADDR_WIDTH-1:0] RegRdAddrB,
    input  logic [DATA_WIDTH-1:0]     RegRdDataA,
    input  logic [DATA_WIDTH-1:0]     RegRdDataB,
    output Opcode_t                   AluOpCode,
    output logic [DATA_WIDTH-1:0]     AluOp1,
    output logic [DATA_WIDTH-1:0]     AluOp2,
    output logic                      AluCarryIn,
    input  logic [DATA_WIDTH-1:0]     AluResult,
    input  logic [3:0]                AluFlags,
    output logic                      RegWe,
    output logic [REG_ADDR_WIDTH-1:0] RegWrAddr,
    output logic [DATA_WIDTH-1:0]     RegWrData,
    output logic [3:0]                FlagsOut,
    output logic                      Busy
);

    IssueState_t               state_q, state_d;
    Opcode_t                   op_q, op_d;
    logic [REG_ADDR_WIDTH-1:0] rd_q, rd_d;
    logic [REG_ADDR_WIDTH-1:0] ra_q, ra_d;
    logic [REG_ADDR_WIDTH-1:0] rb_q, rb_d;
    logic [DATA_WIDTH-1:0]     imm_q, imm_d;
    logic                      use_imm_q, use_imm_d;
    logic [3:0]                flags_q, flags_d;
    logic                      reg_we_q, reg_we_d;
    logic [REG_ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0]     wr_data_q, wr_data_d;

    logic in_read;
    logic in_exec;
    logic accept;

    assign in_read    = (state_q == READ);
    assign in_exec    = (state_q == EXEC);
    assign InstrReady = nReset && (state_q == IDLE);
    assign accept     = InstrValid && InstrReady;

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        rd_d      = rd_q;
        ra_d      = ra_q;
        rb_d      = rb_q;
        imm_d     = imm_q;
        use_imm_d = use_imm_q;
        flags_d   = flags_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        // Write enable is a one-cycle pulse covering only WB.
        reg_we_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    op_d      = InstrOp;
                    rd_d      = InstrRd;
                    ra_d      = InstrRa;
                    rb_d      = InstrRb;
                    imm_d     = InstrImm;
                    use_imm_d = InstrUseImm;
                    state_d   = READ;
                end
            end
            READ: begin
                state_d = EXEC;
            end
            EXEC: begin
                // Address/data load even when the write is suppressed.
                wr_data_d = AluResult;
                wr_addr_d = rd_q;
                reg_we_d  = writes_back(op_q);
                if (sets_flags(op_q)) begin
                    flags_d = AluFlags;
                end
                state_d = WB;
            end
            WB: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock) begin
        if (!nReset) begin
            state_q   <= IDLE;
            op_q      <= Opcode_t'('0);
            rd_q      <= '0;
            ra_q      <= '0;
            rb_q      <= '0;
            imm_q     <= '0;
            use_imm_q <= 1'b0;
            flags_q   <= '0;
            reg_we_q  <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            rd_q      <= rd_d;
            ra_q      <= ra_d;
            rb_q      <= rb_d;
            imm_q     <= imm_d;
            use_imm_q <= use_imm_d;
            flags_q   <= flags_d;
            reg_we_q  <= reg_we_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign RegRdAddrA = in_read ? ra_q : '0;
    assign RegRdAddrB = in_read ? rb_q : '0;

    assign AluOpCode  = op_q;
    assign AluOp1     = in_exec ? RegRdDataA : '0;
    assign AluOp2     = in_exec ? (use_imm_q ? imm_q : RegRdDataB) : '0;
    // Carry chains from the flags as they stand entering EXEC.
    assign AluCarryIn = in_exec && uses_carry(op_q) && flags_q[FLAGS_C];

    assign RegWe      = reg_we_q;
    assign RegWrAddr  = wr_addr_q;
    assign RegWrData  = wr_data_q;
    assign FlagsOut   = flags_q;
    assign Busy       = (state_q != IDLE);

endmodule

// File: tb/tb_alu_issue.sv
// Bench for alu_issue: register file and ALU environment, a behavioural
// reference checked every cycle, directed literals and random traffic.
module tb_alu_issue;
    import opcodes::*;

    logic        Clock;
    logic        nReset;
    logic        InstrValid;
    logic        InstrReady;
    Opcode_t     InstrOp;
    logic [2:0]  InstrRd, InstrRa, InstrRb;
    logic [15:0] InstrImm;
    logic        InstrUseImm;
    logic [2:0]  RegRdAddrA, RegRdAddrB;
    logic [15:0] RegRdDataA, RegRdDataB;
    Opcode_t     AluOpCode;
    logic [15:0] AluOp1, AluOp2;
    logic        AluCarryIn;
    logic [15:0] AluResult;
    logic [3:0]  AluFlags;
    logic        RegWe;
    logic [2:0]  RegWrAddr;
    logic [15:0] RegWrData;
    logic [3:0]  FlagsOut;
    logic        Busy;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    alu_issue dut (
        .Clock(Clock), .nReset(nReset),
        .InstrValid(InstrValid), .InstrReady(InstrReady),
        .InstrOp(InstrOp), .InstrRd(InstrRd),
        .InstrRa(InstrRa), .InstrRb(InstrRb),
        .InstrImm(InstrImm), .InstrUseImm(InstrUseImm),
        .RegRdAddrA(RegRdAddrA), .RegRdAddrB(RegRdAddrB),
        .RegRdDataA(RegRdDataA), .RegRdDataB(RegRdDataB),
        .AluOpCode(AluOpCode), .AluOp1(AluOp1), .AluOp2(AluOp2),
        .AluCarryIn(AluCarryIn), .AluResult(AluResult),
        .AluFlags(AluFlags), .RegWe(RegWe), .RegWrAddr(RegWrAddr),
        .RegWrData(RegWrData), .FlagsOut(FlagsOut), .Busy(Busy)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;
    always @(posedge Clock) cyc <= cyc + 1;

    // Behavioural 16-bit ALU: returns {result, flags}.
    function automatic logic [19:0] alu_f(Opcode_t op, logic [15:0] a,
                                          logic [15:0] b, logic cin);
        logic [16:0] s;
        logic [15:0] r;
        logic [3:0]  f;
        logic        c, v;
        s = '0; r = '0; c = 1'b0; v = 1'b0;
        case (op)
            ADD, ADDI, ADDIB, ADC, ADCI: begin
                s = {1'b0, a} + {1'b0, b} + {16'd0, cin && (op inside {ADC, ADCI})};
                r = s[15:0]; c = s[16];
                v = (a[15] == b[15]) && (r[15] != a[15]);
            end
            SUB, SUBI, SUBIB, CMP, CMPI, SUC, SUCI: begin
                s = {1'b0, a} + {1'b0, ~b} +
                    ((op inside {SUC, SUCI}) ? {16'd0, cin} : 17'd1);
                r = s[15:0]; c = s[16];
                v = (a[15] != b[15]) && (r[15] != a[15]);
            end
            NEG: begin
                r = -a; c = (a != 16'd0); v = (a == 16'h8000);
            end
            AND:  r = a & b;
            OR:   r = a | b;
            XOR:  r = a ^ b;
            NOT:  r = ~a;
            NAND: r = ~(a & b);
            NOR:  r = ~(a | b);
            LSL:  r = a << b[3:0];
            LSR:  r = a >> b[3:0];
            ASR:  r = $signed(a) >>> b[3:0];
            LUI:  r = {b[7:0], a[7:0]};
            LLI:  r = {a[15:8], b[7:0]};
            LDW, POP: r = b;
            default: r = a;
        endcase
        f = '0;
        f[FLAGS_Z] = (r == 16'd0);
        f[FLAGS_N] = r[15];
        f[FLAGS_C] = c;
        f[FLAGS_V] = v;
        return {r, f};
    endfunction

    assign {AluResult, AluFlags} = alu_f(AluOpCode, AluOp1, AluOp2, AluCarryIn);

    // Register file environment: synchronous 1-cycle read.
    logic [15:0] rf [8] = '{default: 16'd0};
    initial begin
        RegRdDataA = '0;
        RegRdDataB = '0;
    end
    always @(posedge Clock) begin
        RegRdDataA <= rf[RegRdAddrA];
        RegRdDataB <= rf[RegRdAddrB];
        if (RegWe) rf[RegWrAddr] <= RegWrData;
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: age counts cycles since the accepting edge.
    int          age = 0;
    Opcode_t     m_op = Opcode_t'(0);
    logic [2:0]  m_rd = '0, m_ra = '0, m_rb = '0;
    logic [15:0] m_a = '0, m_b = '0, m_res = '0;
    logic [3:0]  m_fl = '0, m_flags = '0;
    logic        m_cin = 1'b0, m_wb = 1'b0;
    logic [2:0]  m_waddr = '0;
    logic [15:0] m_wdata = '0;
    logic [15:0] ref_regs [8] = '{default: 16'd0};

    always @(negedge Clock) begin
        chk("ready", InstrReady, (age == 0) && nReset);
        chk("busy", Busy, age != 0);
        chk("we", RegWe, (age == 3) && m_wb);
        chk("waddr", RegWrAddr, m_waddr);
        chk("wdata", RegWrData, m_wdata);
        chk("flags", FlagsOut, m_flags);
        chk("opcode", AluOpCode, m_op);
        chk("rdaddr_a", RegRdAddrA, (age == 1) ? m_ra : 3'd0);
        chk("rdaddr_b", RegRdAddrB, (age == 1) ? m_rb : 3'd0);
        chk("op1", AluOp1, (age == 2) ? m_a : 16'd0);
        chk("op2", AluOp2, (age == 2) ? m_b : 16'd0);
        chk("cin", AluCarryIn, (age == 2) && m_cin);
        // The RF still takes a write pending at a reset edge.
        if (age == 3 && m_wb) ref_regs[m_rd] = m_res;
        if (!nReset) begin
            age = 0; m_op = Opcode_t'(0);
            m_rd = '0; m_ra = '0; m_rb = '0;
            m_flags = '0; m_wb = 1'b0;
            m_waddr = '0; m_wdata = '0;
        end else if (age == 0) begin
            if (InstrValid) begin
                m_op = InstrOp; m_rd = InstrRd;
                m_ra = InstrRa; m_rb = InstrRb;
                m_a = ref_regs[InstrRa];
                m_b = InstrUseImm ? InstrImm : ref_regs[InstrRb];
                m_cin = (InstrOp inside {ADC, ADCI, SUC, SUCI}) && m_flags[FLAGS_C];
                {m_res, m_fl} = alu_f(InstrOp, m_a, m_b, m_cin);
                m_wb = writes_back(InstrOp);
                age = 1;
            end
        end else if (age == 2) begin
            m_wdata = m_res; m_waddr = m_rd;
            if (sets_flags(m_op)) m_flags = m_fl;
            age = 3;
        end else if (age == 3) begin
            age = 0;
        end else begin
            age = age + 1;
        end
    end

    // Present an instruction and return two ns after the accepting edge.
    task automatic issue(input Opcode_t op, input logic [2:0] rd,
                         input logic [2:0] ra, input logic [2:0] rb,
                         input logic [15:0] imm, input logic ui);
        logic got;
        got = 1'b0;
        @(posedge Clock); #2;
        InstrOp = op; InstrRd = rd; InstrRa = ra; InstrRb = rb;
        InstrImm = imm; InstrUseImm = ui; InstrValid = 1'b1;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge Clock);
            if (InstrReady) got = 1'b1;
        end
        chk("accept", got, 1'b1);
        @(posedge Clock); #2;
        InstrValid = 1'b0;
    endtask

    task automatic run(input Opcode_t op, input logic [2:0] rd,
                       input logic [2:0] ra, input logic [2:0] rb,
                       input logic [15:0] imm, input logic ui,
                       output logic [15:0] op2, output logic cin,
                       output logic we, output logic [15:0] wd,
                       output logic [2:0] wa, output logic [3:0] fl);
        issue(op, rd, ra, rb, imm, ui);
        @(negedge Clock);
        @(negedge Clock);
        op2 = AluOp2; cin = AluCarryIn;
        @(negedge Clock);
        we = RegWe; wd = RegWrData; wa = RegWrAddr; fl = FlagsOut;
    endtask

    task automatic load(input logic [2:0] r, input logic [15:0] v);
        logic [15:0] o2, wd;
        logic        ci, we;
        logic [2:0]  wa;
        logic [3:0]  fl;
        run(LLI, r, r, 3'd0, {8'd0, v[7:0]}, 1'b1, o2, ci, we, wd, wa, fl);
        run(LUI, r, r, 3'd0, {8'd0, v[15:8]}, 1'b1, o2, ci, we, wd, wa, fl);
    endtask

    Opcode_t     b_op [3];
    logic [2:0]  b_rd [3];
    logic [2:0]  b_ra [3];
    int          acc [3];
    int          nacc;
    logic [15:0] o2, wd;
    logic        ci, we;
    logic [2:0]  wa;
    logic [3:0]  fl;

    initial begin
        nReset = 1'b0; InstrValid = 1'b0; InstrOp = ADD;
        InstrRd = '0; InstrRa = '0; InstrRb = '0;
        InstrImm = '0; InstrUseImm = 1'b0;
        repeat (3) @(posedge Clock);
        @(negedge Clock);
        chk("rst_ready", InstrReady, 1'b0);
        chk("rst_flags", FlagsOut, 4'd0);
        chk("rst_we", RegWe, 1'b0);
        @(posedge Clock); #2;
        nReset = 1'b1;

        load(3'd1, 16'h0003);
        load(3'd2, 16'h0004);
        run(ADD, 3'd3, 3'd1, 3'd2, 16'd0, 1'b0, o2, ci, we, wd, wa, fl);
        chk("add_we", we, 1'b1);
        chk("add_wa", wa, 3'd3);
        chk("add_wd", wd, 16'h0007);
        chk("add_fl", fl, 4'b0000);

        load(3'd1, 16'h0005);
        load(3'd2, 16'h0005);
        run(SUB, 3'd3, 3'd1, 3'd2, 16'd0, 1'b0, o2, ci, we, wd, wa, fl);
        chk("sub_wd", wd, 16'h0000);
        chk("sub_z", fl[FLAGS_Z], 1'b1);
        run(LUI, 3'd4, 3'd4, 3'd0, 16'h0012, 1'b1, o2, ci, we, wd, wa, fl);
        chk("lui_fl", fl, 4'b0101);
        chk("lui_wd", wd, 16'h1200);

        load(3'd1, 16'hFFFF);
        load(3'd2, 16'h0001);
        run(ADD, 3'd3, 3'd1, 3'd2, 16'd0, 1'b0, o2, ci, we, wd, wa, fl);
        chk("addc_c", fl[FLAGS_C], 1'b1);
        run(ADC, 3'd5, 3'd6, 3'd7, 16'd0, 1'b0, o2, ci, we, wd, wa, fl);
        chk("adc_cin", ci, 1'b1);
        chk("adc_wd", wd, 16'h0001);

        load(3'd4, 16'h0010);
        run(CMPI, 3'd7, 3'd4, 3'd0, 16'h0010, 1'b1, o2, ci, we, wd, wa, fl);
        chk("cmpi_op2", o2, 16'h0010);
        chk("cmpi_we", we, 1'b0);
        chk("cmpi_z", fl[FLAGS_Z], 1'b1);

        // Reset while an ADD sits in EXEC.
        issue(ADD, 3'd3, 3'd1, 3'd2, 16'd0, 1'b0);
        @(posedge Clock); #2;
        nReset = 1'b0;
        @(posedge Clock); #2;
        nReset = 1'b1;
        @(negedge Clock);
        chk("abort_ready", InstrReady, 1'b1);
        chk("abort_flags", FlagsOut, 4'd0);
        chk("abort_we", RegWe, 1'b0);
        chk("abort_busy", Busy, 1'b0);

        // Valid held high across three back-to-back instructions.
        b_op[0] = ADD; b_rd[0] = 3'd5; b_ra[0] = 3'd1;
        b_op[1] = ADD; b_rd[1] = 3'd6; b_ra[1] = 3'd5;
        b_op[2] = XOR; b_rd[2] = 3'd7; b_ra[2] = 3'd6;
        @(posedge Clock); #2;
        nacc = 0;
        InstrOp = b_op[0]; InstrRd = b_rd[0]; InstrRa = b_ra[0];
        InstrRb = 3'd2; InstrUseImm = 1'b0; InstrValid = 1'b1;
        for (int g = 0; g < 40 && nacc < 3; g++) begin
            @(negedge Clock);
            if (InstrReady) begin
                acc[nacc] = cyc;
                nacc++;
                @(posedge Clock); #2;
                if (nacc < 3) begin
                    InstrOp = b_op[nacc]; InstrRd = b_rd[nacc];
                    InstrRa = b_ra[nacc];
                end
            end
        end
        InstrValid = 1'b0;
        chk("burst_n", nacc, 3);
        chk("burst_gap1", acc[1] - acc[0], 4);
        chk("burst_gap2", acc[2] - acc[1], 4);

        for (int n = 0; n < 80; n++) begin
            issue(Opcode_t'($urandom_range(0, 29)), 3'($urandom_range(0, 7)),
                  3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                  16'($urandom), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 9) == 0) begin
                repeat ($urandom_range(0, 3)) begin
                    @(posedge Clock); #2;
                end
                nReset = 1'b0;
                @(posedge Clock); #2;
                nReset = 1'b1;
            end
        end

        repeat (8) @(posedge Clock);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
